// File: rtl/fp_sqrt_seq.sv
// Sequential single-precision square root: three-step Newton-Raphson on the mantissa
// followed by exponent reconstruction, time-sharing external divider, adder and multiplier.
module fp_sqrt_seq #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ITER    = 3,
  parameter int unsigned DIV_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] A,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            exception,
  output logic            underflow,
  output logic            overflow,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  input  logic [XLEN-1:0] div_result,
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  input  logic [XLEN-1:0] add_result,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  input  logic [XLEN-1:0] mul_result
);

  localparam int unsigned IW = 3;
  localparam int unsigned CW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_DIV   = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_SCALE = 3'd4;
  localparam logic [2:0] S_EXP   = 3'd5;
  localparam logic [2:0] S_ODD   = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [XLEN-1:0] QNAN  = XLEN'(32'h7fc00000);
  localparam logic [XLEN-1:0] X0    = XLEN'(32'h3f5a827a);
  localparam logic [XLEN-1:0] SQRT2 = XLEN'(32'h3fb504f3);

  logic [2:0]      state, state_n;
  logic [XLEN-1:0] a_q, a_n, m_q, m_n, x_q, x_n, q_q, q_n, s_q, s_n;
  logic [8:0]      e_q, e_n;
  logic [IW-1:0]   iter_q, iter_n;
  logic [CW-1:0]   cyc_q, cyc_n;
  logic            busy_n, done_n, exc_n, unf_n;
  logic [XLEN-1:0] result_n;
  logic [XLEN-1:0] div_a_n, div_b_n, add_a_n, add_b_n, mul_a_n, mul_b_n;
  logic [7:0]      a_exp;
  logic [22:0]     a_man;

  assign a_exp = a_q[30:23];
  assign a_man = a_q[22:0];

  // Next-state and next-register computation; outputs are registered from these values.
  always_comb begin
    state_n  = state;
    a_n      = a_q;
    m_n      = m_q;
    x_n      = x_q;
    q_n      = q_q;
    s_n      = s_q;
    e_n      = e_q;
    iter_n   = iter_q;
    cyc_n    = cyc_q;
    busy_n   = busy;
    done_n   = 1'b0;
    result_n = result;
    exc_n    = exception;
    unf_n    = underflow;
    div_a_n  = '0;
    div_b_n  = '0;
    add_a_n  = '0;
    add_b_n  = '0;
    mul_a_n  = '0;
    mul_b_n  = '0;

    case (state)
      S_IDLE: begin
        if (start) begin
          a_n     = A;
          exc_n   = 1'b0;
          unf_n   = 1'b0;
          busy_n  = 1'b1;
          state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        state_n = S_DONE;
        if (a_exp == 8'hff && a_man != 23'd0) begin
          result_n = QNAN;
          exc_n    = 1'b1;
        end else if (a_exp == 8'd0) begin
          // Zeros pass through; denormals flush to a signed zero.
          result_n = {a_q[31], 31'd0};
          unf_n    = (a_man != 23'd0);
        end else if (a_q[31]) begin
          result_n = QNAN;
          exc_n    = 1'b1;
        end else if (a_exp == 8'hff) begin
          result_n = a_q;
        end else begin
          m_n     = {1'b0, 8'd126, a_man};
          x_n     = X0;
          e_n     = {1'b0, a_exp} - 9'd127;
          iter_n  = '0;
          cyc_n   = '0;
          state_n = S_DIV;
        end
      end
      S_DIV: begin
        if (cyc_q == CW'(DIV_LAT - 1)) begin
          q_n     = div_result;
          cyc_n   = '0;
          state_n = S_ADD;
        end else begin
          cyc_n = cyc_q + CW'(1);
        end
      end
      S_ADD: begin
        // (q + x) / 2 by decrementing the exponent of the sum.
        x_n     = {add_result[31], add_result[30:23] - 8'd1, add_result[22:0]};
        iter_n  = iter_q + IW'(1);
        state_n = (32'(iter_n) < ITER) ? S_DIV : S_SCALE;
      end
      S_SCALE: begin
        s_n     = mul_result;
        state_n = S_EXP;
      end
      S_EXP: begin
        // Low 8 bits of e >>> 1 are e[8:1].
        s_n[30:23] = s_q[30:23] + e_q[8:1];
        if (e_q[0]) begin
          state_n = S_ODD;
        end else begin
          result_n = s_n;
          state_n  = S_DONE;
        end
      end
      S_ODD: begin
        s_n      = mul_result;
        result_n = mul_result;
        state_n  = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (state_n == S_DONE) begin
      done_n = 1'b1;
      busy_n = 1'b0;
    end

    // Operands are registered for the state being entered so they are stable throughout it.
    case (state_n)
      S_DIV: begin
        div_a_n = m_n;
        div_b_n = x_n;
      end
      S_ADD: begin
        add_a_n = q_n;
        add_b_n = x_n;
      end
      S_SCALE: begin
        mul_a_n = x_n;
        mul_b_n = SQRT2;
      end
      S_ODD: begin
        mul_a_n = s_n;
        mul_b_n = SQRT2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      a_q       <= '0;
      m_q       <= '0;
      x_q       <= '0;
      q_q       <= '0;
      s_q       <= '0;
      e_q       <= '0;
      iter_q    <= '0;
      cyc_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      exception <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
      add_a     <= '0;
      add_b     <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      state     <= state_n;
      a_q       <= a_n;
      m_q       <= m_n;
      x_q       <= x_n;
      q_q       <= q_n;
      s_q       <= s_n;
      e_q       <= e_n;
      iter_q    <= iter_n;
      cyc_q     <= cyc_n;
      busy      <= busy_n;
      done      <= done_n;
      result    <= result_n;
      exception <= exc_n;
      underflow <= unf_n;
      overflow  <= 1'b0;
      div_a     <= div_a_n;
      div_b     <= div_b_n;
      add_a     <= add_a_n;
      add_b     <= add_b_n;
      mul_a     <= mul_a_n;
      mul_b     <= mul_b_n;
    end
  end

endmodule

// File: tb/tb_fp_sqrt_seq.sv
// Bench for fp_sqrt_seq: ideal round-to-nearest FP unit models, directed cases,
// reset abort, back-to-back issue and a random sweep against a real-valued sqrt.
module tb_fp_sqrt_seq;

  localparam int ITER    = 3;
  localparam int DIV_LAT = 2;

  logic        clk, rst, start;
  logic [31:0] A;
  logic        busy, done, exception, underflow, overflow;
  logic [31:0] result;
  logic [31:0] div_a, div_b, div_result;
  logic [31:0] add_a, add_b, add_result;
  logic [31:0] mul_a, mul_b, mul_result;

  fp_sqrt_seq #(.XLEN(32), .ITER(ITER), .DIV_LAT(DIV_LAT)) u_dut (
    .clk(clk), .rst(rst), .start(start), .A(A),
    .busy(busy), .done(done), .result(result),
    .exception(exception), .underflow(underflow), .overflow(overflow),
    .div_a(div_a), .div_b(div_b), .div_result(div_result),
    .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic        unf;
    int          lat;
    int          tol;
    int          t0;
  } exp_t;

  exp_t sb[$];

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    logic [23:0] mt;
    if (r == 0.0) return 32'd0;
    d  = $realtobits(r);
    e  = int'(d[62:52]) - 896;
    mt = {1'b0, d[51:29]};
    if (d[28] && ((|d[27:0]) || mt[0])) mt = mt + 24'd1;
    if (mt[23]) begin
      mt = 24'd0;
      e  = e + 1;
    end
    return {d[63], e[7:0], mt[22:0]};
  endfunction

  // Ideal units: adder and multiplier combinational, divider valid after DIV_LAT stable cycles.
  always_comb add_result = r2f(f2r(add_a) + f2r(add_b));
  always_comb mul_result = r2f(f2r(mul_a) * f2r(mul_b));

  logic [31:0] pa = 32'd0, pb = 32'd0;
  int          stab = 0;
  initial div_result = 32'hdeadbeef;
  always @(negedge clk) begin
    if (div_a == pa && div_b == pb) begin
      if (stab < 1000) stab = stab + 1;
    end else begin
      stab = 1;
    end
    pa = div_a;
    pb = div_b;
    if (stab >= DIV_LAT && div_b != 32'd0) div_result = r2f(f2r(div_a) / f2r(div_b));
    else div_result = 32'hdeadbeef;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_ulp(input string tag, input logic [31:0] obs, input logic [31:0] expv,
                         input int tol);
    longint d;
    d = longint'({32'd0, obs}) - longint'({32'd0, expv});
    if (d < 0) d = -d;
    tests++;
    assert (d <= longint'(tol)) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (+-%0d ulp)", tag, obs, expv, tol);
    end
  endtask

  // Called at a negedge: that cycle becomes cycle 0 of the operation.
  task automatic start_op(input logic [31:0] a, input logic [31:0] res, input logic exc,
                          input logic unf, input int lat, input int tol);
    exp_t e;
    e.res = res; e.exc = exc; e.unf = unf; e.lat = lat; e.tol = tol; e.t0 = cyc;
    sb.push_back(e);
    start = 1'b1;
    A     = a;
    @(negedge clk);
    start = 1'b0;
    A     = $urandom;
    chk("busy_c1", 32'(busy), 32'd1);
    chk("exc_cleared", 32'(exception), 32'd0);
    chk("unf_cleared", 32'(underflow), 32'd0);
  endtask

  // Returns at the negedge of the done cycle.
  task automatic wait_check(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    if (done === 1'b1) begin
      chk({tag, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
      chk_ulp({tag, "_result"}, result, e.res, e.tol);
      chk({tag, "_exception"}, 32'(exception), 32'(e.exc));
      chk({tag, "_underflow"}, 32'(underflow), 32'(e.unf));
      chk({tag, "_overflow"}, 32'(overflow), 32'd0);
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic gap();
    @(negedge clk);
    chk("done_pulse_1cyc", 32'(done), 32'd0);
    chk("idle_div_a", div_a, 32'd0);
    chk("idle_add_a", add_a, 32'd0);
    chk("idle_mul_a", mul_a, 32'd0);
  endtask

  function automatic int norm_lat(input logic [31:0] a);
    return 2 + ITER * (DIV_LAT + 1) + 2 + ((int'(a[30:23]) - 127) & 1);
  endfunction

  initial begin
    logic [31:0] a;
    int          t0;
    int          ndone;
    rst   = 1'b1;
    start = 1'b0;
    A     = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_exc", 32'(exception), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_div_b", div_b, 32'd0);
    chk("rst_add_b", add_b, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    start_op(32'h40800000, 32'h40000000, 1'b0, 1'b0, 13, 2); wait_check("sqrt4"); gap();
    start_op(32'h40000000, 32'h3fb504f3, 1'b0, 1'b0, 14, 2); wait_check("sqrt2"); gap();
    start_op(32'h3e800000, 32'h3f000000, 1'b0, 1'b0, 13, 2); wait_check("sqrt025"); gap();
    start_op(32'hc0800000, 32'h7fc00000, 1'b1, 1'b0, 2, 0);  wait_check("neg4"); gap();
    start_op(32'h00000001, 32'h00000000, 1'b0, 1'b1, 2, 0);  wait_check("denorm"); gap();
    start_op(32'h80000001, 32'h80000000, 1'b0, 1'b1, 2, 0);  wait_check("neg_denorm"); gap();
    start_op(32'h00000000, 32'h00000000, 1'b0, 1'b0, 2, 0);  wait_check("pos_zero"); gap();
    start_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, 2, 0);  wait_check("neg_zero"); gap();
    start_op(32'h7f800000, 32'h7f800000, 1'b0, 1'b0, 2, 0);  wait_check("pos_inf"); gap();
    start_op(32'hff800000, 32'h7fc00000, 1'b1, 1'b0, 2, 0);  wait_check("neg_inf"); gap();
    start_op(32'h7f800001, 32'h7fc00000, 1'b1, 1'b0, 2, 0);  wait_check("nan"); gap();
    start_op(32'h41100000, 32'h40400000, 1'b0, 1'b0, 14, 2); wait_check("sqrt9"); gap();

    // start in the DONE cycle is ignored; the following cycle is accepted
    start_op(32'h40800000, 32'h40000000, 1'b0, 1'b0, 13, 2); wait_check("b2b_first");
    start = 1'b1;
    A     = 32'h3e800000;
    @(negedge clk);
    chk("b2b_done_low", 32'(done), 32'd0);
    start_op(32'h40000000, 32'h3fb504f3, 1'b0, 1'b0, 14, 2); wait_check("b2b_second"); gap();

    // Abort by reset mid-operation, with a start pulse while busy
    ndone = 0;
    t0    = cyc;
    start = 1'b1;
    A     = 32'h40800000;
    @(negedge clk);
    start = 1'b0;
    while (cyc - t0 < 5) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    start = 1'b1;
    A     = 32'h40000000;
    @(negedge clk);
    start = 1'b0;
    if (done === 1'b1) ndone++;
    @(negedge clk);
    rst = 1'b1;
    if (done === 1'b1) ndone++;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    start_op(32'h41100000, 32'h40400000, 1'b0, 1'b0, 14, 2); wait_check("after_abort"); gap();

    // Random positive normals against a real-valued reference
    for (int i = 0; i < 300; i++) begin
      a = {1'b0, 8'($urandom_range(254, 1)), 23'($urandom)};
      start_op(a, r2f($sqrt(f2r(a))), 1'b0, 1'b0, norm_lat(a), 2);
      wait_check("rand");
      gap();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
